// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/FLUSH/HALT with a one-cycle bubble after taken branches.
// Optional performance counters are enabled by defining PC_FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
    parameter int PW       = 10,
    parameter int OW       = 8,
    parameter int START_PC = 0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Branch_en,
    input  logic          Jump,
    input  logic [OW-1:0] Offset,
    input  logic          Halt_req,
    output logic [PW-1:0] PC,
    output logic          Fetch_valid,
    output logic          Done
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   Cycle_count,
    output logic [15:0]   Taken_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [PW-1:0] START_PC_L = PW'(START_PC);

    state_t              state_q;
    logic [PW-1:0]       pc_q;
    logic                fetch_valid_q;
    logic                done_q;
    logic signed [PW-1:0] off_ext;
    logic [PW-1:0]       pc_inc_d;
    logic [PW-1:0]       pc_tgt_d;
    logic                taken_d;

    // Gating Jump with Branch_en keeps an unknown Jump out of the next-state logic.
    assign taken_d  = Branch_en && Jump;
    assign off_ext  = PW'($signed(Offset));
    assign pc_inc_d = pc_q + PW'(1);
    assign pc_tgt_d = pc_q + off_ext;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (Start) begin
                        pc_q          <= START_PC_L;
                        state_q       <= RUN;
                        fetch_valid_q <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                RUN: begin
                    if (Stall) begin
                        state_q <= RUN;
                    end else if (Halt_req) begin
                        state_q       <= HALT;
                        fetch_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                    end else if (taken_d) begin
                        pc_q          <= pc_tgt_d;
                        state_q       <= FLUSH;
                        fetch_valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                FLUSH: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= IDLE;
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign PC          = pc_q;
    assign Fetch_valid = fetch_valid_q;
    assign Done        = done_q;

`ifdef PC_FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_q;
    logic [15:0] taken_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else if ((state_q == IDLE || state_q == HALT) && Start) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else if (state_q == RUN) begin
            cycle_cnt_q <= sat_inc(cycle_cnt_q);
            if (!Stall && !Halt_req && taken_d) begin
                taken_cnt_q <= sat_inc(taken_cnt_q);
            end
        end else if (state_q == FLUSH) begin
            cycle_cnt_q <= sat_inc(cycle_cnt_q);
        end
    end

    assign Cycle_count = cycle_cnt_q;
    assign Taken_count = taken_cnt_q;
`endif

endmodule
